// File: rtl/e203_cg_sched.sv
// -----------------------------------------------------------------------------
// e203_cg_sched
// Clock-gating scheduler for the E203 core.
//
// Decides, cycle by cycle, the clock enables for the gated units
// (bit 0=IFU, 1=EXU, 2=LSU, 3=BIU, 4=ITCM, 5=DTCM). Each unit has its own idle
// hysteresis. The block also sequences core sleep entry and exit around WFI:
// RUN -> DRAIN -> SLEEP -> WAKE -> RUN.
//
// Ports:
//   clk            core clock (ungated)
//   rst            synchronous, active-high reset
//   test_mode      DFT override; forces every enable high
//   core_cgstop    software gating disable; forces every enable high
//   unit_active    per-unit busy indication
//   core_wfi       core requests sleep (level)
//   wake_req       wake event, such as an interrupt or debug request (level)
//   unit_clk_en    per-unit clock-gate enable
//   core_clk_en    core-level clock-gate enable
//   core_sleep_ack sleep granted; the core clock is off
// -----------------------------------------------------------------------------
module e203_cg_sched #(
    parameter int N_UNIT    = 6,
    parameter int IDLE_HOLD = 8,   // legal range 1..15
    parameter int WAKE_DLY  = 2    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              core_cgstop,
    input  logic [N_UNIT-1:0] unit_active,
    input  logic              core_wfi,
    input  logic              wake_req,
    output logic [N_UNIT-1:0] unit_clk_en,
    output logic              core_clk_en,
    output logic              core_sleep_ack
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(IDLE_HOLD - 1);
    localparam logic [3:0] WAKE_MAX = 4'(WAKE_DLY - 1);

    state_t            state_q, state_d;
    logic [3:0]        wk_cnt_q, wk_cnt_d;
    logic              ack_q, ack_d;
    logic [N_UNIT-1:0] en_q, en_d;
    logic [3:0]        cnt_q [N_UNIT];
    logic [3:0]        cnt_d [N_UNIT];
    logic              ovr_s;
    logic              wake_all_s;

    // Override is purely combinational; internal state keeps advancing.
    always_comb begin
        ovr_s = test_mode | core_cgstop;
    end

    // Sleep FSM next-state and wake delay counter.
    always_comb begin
        state_d  = state_q;
        wk_cnt_d = 4'd0;
        case (state_q)
            ST_RUN: begin
                if (core_wfi && !wake_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Abort wins over sleep entry.
                if (wake_req || !core_wfi) begin
                    state_d = ST_RUN;
                end else if (unit_active == '0) begin
                    state_d = ST_SLEEP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SLEEP: begin
                if (wake_req) begin
                    state_d = ST_WAKE;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            ST_WAKE: begin
                if (wk_cnt_q == WAKE_MAX) begin
                    state_d  = ST_RUN;
                    wk_cnt_d = 4'd0;
                end else begin
                    state_d  = ST_WAKE;
                    wk_cnt_d = wk_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d  = ST_RUN;
                wk_cnt_d = 4'd0;
            end
        endcase
        ack_d = (state_d == ST_SLEEP);
    end

    // Units must already be enabled on the edge that enters WAKE, so the
    // SLEEP->WAKE transition is treated the same as being in WAKE.
    always_comb begin
        wake_all_s = (state_q == ST_WAKE) || (state_d == ST_WAKE);
    end

    // Per-unit idle hysteresis; the counter saturates at IDLE_HOLD-1.
    always_comb begin
        en_d = en_q;
        for (int i = 0; i < N_UNIT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wake_all_s) begin
                en_d[i]  = 1'b1;
                cnt_d[i] = 4'd0;
            end else if (state_q == ST_SLEEP) begin
                en_d[i]  = 1'b0;
                cnt_d[i] = 4'd0;
            end else if (unit_active[i]) begin
                en_d[i]  = 1'b1;
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == HOLD_MAX) begin
                en_d[i]  = 1'b0;
                cnt_d[i] = cnt_q[i];
            end else begin
                en_d[i]  = en_q[i];
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    // State register for the FSM, counters, enables and sleep ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wk_cnt_q <= 4'd0;
            ack_q    <= 1'b0;
            en_q     <= '1;
            for (int i = 0; i < N_UNIT; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            wk_cnt_q <= wk_cnt_d;
            ack_q    <= ack_d;
            en_q     <= en_d;
            for (int i = 0; i < N_UNIT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Output mapping: registered state combined with the override.
    always_comb begin
        unit_clk_en    = en_q | {N_UNIT{ovr_s}};
        core_clk_en    = (state_q != ST_SLEEP) | ovr_s;
        core_sleep_ack = ack_q;
    end

endmodule

// File: tb/tb_e203_cg_sched.sv
module tb_e203_cg_sched;

    logic       clk;
    logic       rst;
    logic       test_mode;
    logic       core_cgstop;
    logic [5:0] unit_active;
    logic       core_wfi;
    logic       wake_req;
    logic [5:0] unit_clk_en;
    logic       core_clk_en;
    logic       core_sleep_ack;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic [5:0] ua;
        logic       wfi;
        logic       wk;
        logic [5:0] exp_en;
        logic       exp_cce;
        logic       exp_ack;
    } vec_t;

    vec_t vq[$];

    e203_cg_sched #(.N_UNIT(6), .IDLE_HOLD(8), .WAKE_DLY(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .test_mode      (test_mode),
        .core_cgstop    (core_cgstop),
        .unit_active    (unit_active),
        .core_wfi       (core_wfi),
        .wake_req       (wake_req),
        .unit_clk_en    (unit_clk_en),
        .core_clk_en    (core_clk_en),
        .core_sleep_ack (core_sleep_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addv(input logic r, input logic [5:0] ua, input logic wfi,
                        input logic wk, input logic [5:0] en, input logic cce,
                        input logic ack);
        vec_t v;
        v.rst = r; v.ua = ua; v.wfi = wfi; v.wk = wk;
        v.exp_en = en; v.exp_cce = cce; v.exp_ack = ack;
        vq.push_back(v);
    endtask

    task automatic apply(input logic r, input logic tm, input logic cs,
                         input logic [5:0] ua, input logic wfi, input logic wk);
        rst = r; test_mode = tm; core_cgstop = cs;
        unit_active = ua; core_wfi = wfi; wake_req = wk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [5:0] en,
                        input logic cce, input logic ack);
        chk({name, ".unit_clk_en"}, unit_clk_en, en);
        chk({name, ".core_clk_en"}, {5'd0, core_clk_en}, {5'd0, cce});
        chk({name, ".core_sleep_ack"}, {5'd0, core_sleep_ack}, {5'd0, ack});
    endtask

    initial begin
        apply(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);

        // Reset held two cycles.
        addv(1'b1, 6'h00, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0);
        addv(1'b1, 6'h00, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0);
        // Idle after release: gated on the 8th edge.
        for (int i = 0; i < 7; i++) addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        // LSU: 1 active, 7 idle, 1 active, then 8 idle.
        addv(1'b0, 6'h04, 1'b0, 1'b0, 6'h04, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h04, 1'b1, 1'b0);
        addv(1'b0, 6'h04, 1'b0, 1'b0, 6'h04, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h04, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        // Sleep entry: DRAIN, then SLEEP; activity and wfi ignored in SLEEP.
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
        addv(1'b0, 6'h3F, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
        addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
        // Wake: WAKE for 2 edges, then RUN.
        addv(1'b0, 6'h00, 1'b0, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0);
        // Back in RUN: wfi takes two edges to sleep; enables forced low in SLEEP.
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h3F, 1'b0, 1'b1);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);
        // Wake with wfi still high, then wfi+wake both high in RUN stays RUN.
        addv(1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h3F, 1'b0, 1'b1);
        addv(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].rst, 1'b0, 1'b0, vq[i].ua, vq[i].wfi, vq[i].wk);
            step();
            chk3($sformatf("vec%0d", i), vq[i].exp_en, vq[i].exp_cce, vq[i].exp_ack);
        end

        // Override in SLEEP: combinational, state untouched.
        apply(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
        #1 chk3("ovr_tm", 6'h3F, 1'b1, 1'b1);
        step();
        chk3("ovr_tm_hold", 6'h3F, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        #1 chk3("ovr_tm_off", 6'h00, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0);
        #1 chk3("ovr_cs", 6'h3F, 1'b1, 1'b1);
        step();
        chk3("ovr_cs_hold", 6'h3F, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        #1 chk3("ovr_cs_off", 6'h00, 1'b0, 1'b1);

        // Reset mid-SLEEP.
        apply(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        step();
        chk3("rst_sleep", 6'h3F, 1'b1, 1'b0);

        // Drain abort: EXU busy 5 cycles, wake_req on cycle 3.
        for (int c = 1; c <= 5; c++) begin
            apply(1'b0, 1'b0, 1'b0, 6'h02, 1'b1, (c == 3) ? 1'b1 : 1'b0);
            step();
            chk3($sformatf("abort_a_c%0d", c), 6'h3F, 1'b1, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        step();
        chk3("abort_a_c6", 6'h3F, 1'b1, 1'b0);

        // Abort has priority over sleep entry when all units are idle.
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        step();
        chk3("abort_b_c1", 6'h3F, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b1);
        step();
        chk3("abort_b_c2", 6'h02, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        step();
        chk3("abort_b_c3", 6'h02, 1'b1, 1'b0);
        step();
        chk3("abort_b_c4", 6'h02, 1'b0, 1'b1);
        step();
        chk3("abort_b_c5", 6'h00, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
        step();
        chk3("abort_b_wake", 6'h3F, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
